multicycle_control: RTL and testbench

//  Multicycle control FSM for the CPU datapath. Sequences fetch, decode, execute, memory and write-back per instruction.

---
 rtl/multicycle_control.sv | 193 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM: IF/DEC/EX/MEM/WB/BR sequencing, datapath enables,
// and the data-memory handshake with a no-ack timeout that raises bus_err.
module multicycle_control #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [3:0] func,
  input  logic       alu_zero,
  input  logic       dmem_ack,
  output logic       instr_load,
  output logic       pc_load,
  output logic       pc_sel,
  output logic       rf_we,
  output logic       rf_wrdata_sel,
  output logic       alu_a_zero,
  output logic       alu_bin_sel,
  output logic [3:0] alu_op,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       byte_op,
  output logic       illegal,
  output logic       bus_err,
  output logic [2:0] state
);

  // state | meaning
  // IF    | fetch: load IR
  // DEC   | decode: latch opcode, route by class
  // EX    | execute: ALU operation
  // MEM   | data-memory access, wait for ack or timeout
  // WB    | register write-back, advance PC
  // BR    | branch compare, select PC target
  typedef enum logic [2:0] {
    S_IF  = 3'b000,
    S_DEC = 3'b001,
    S_EX  = 3'b010,
    S_MEM = 3'b011,
    S_WB  = 3'b100,
    S_BR  = 3'b101
  } state_t;

  localparam logic [5:0] OP_ALU   = 6'b100000;
  localparam logic [5:0] OP_LI    = 6'b111000;
  localparam logic [5:0] OP_LUI   = 6'b111001;
  localparam logic [5:0] OP_ADDI  = 6'b110000;
  localparam logic [5:0] OP_NANDI = 6'b110010;
  localparam logic [5:0] OP_ORI   = 6'b110011;
  localparam logic [5:0] OP_B     = 6'b111111;
  localparam logic [5:0] OP_BEQ   = 6'b010000;
  localparam logic [5:0] OP_BNE   = 6'b010001;
  localparam logic [5:0] OP_LB    = 6'b000011;
  localparam logic [5:0] OP_LW    = 6'b001111;
  localparam logic [5:0] OP_SB    = 6'b000111;
  localparam logic [5:0] OP_SW    = 6'b011111;

  localparam logic [3:0] CNT_LAST = 4'(MEM_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [5:0] op_q;
  logic [3:0] cnt_q, cnt_d;

  logic       instr_load_c, pc_load_c, pc_sel_c, rf_we_c, rf_wrdata_sel_c;
  logic       alu_a_zero_c, alu_bin_sel_c, dmem_req_c, dmem_we_c, byte_op_c;
  logic       illegal_c, bus_err_c;
  logic [3:0] alu_op_c;

  logic dec_branch, dec_legal, is_load, is_store;

  always_comb begin
    dec_legal = 1'b0;
    case (opcode)
      OP_ALU, OP_LI, OP_LUI, OP_ADDI, OP_NANDI, OP_ORI,
      OP_B, OP_BEQ, OP_BNE, OP_LB, OP_LW, OP_SB, OP_SW: dec_legal = 1'b1;
      default: dec_legal = 1'b0;
    endcase
  end

  assign dec_branch = (opcode == OP_B) || (opcode == OP_BEQ) || (opcode == OP_BNE);
  assign is_load    = (op_q == OP_LB) || (op_q == OP_LW);
  assign is_store   = (op_q == OP_SB) || (op_q == OP_SW);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IF;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == S_DEC) op_q <= opcode;
    end
  end

  always_comb begin
    state_d         = S_IF;
    cnt_d           = '0;
    instr_load_c    = 1'b0;
    pc_load_c       = 1'b0;
    pc_sel_c        = 1'b0;
    rf_we_c         = 1'b0;
    rf_wrdata_sel_c = 1'b0;
    alu_a_zero_c    = 1'b0;
    alu_bin_sel_c   = 1'b0;
    alu_op_c        = 4'b0000;
    dmem_req_c      = 1'b0;
    dmem_we_c       = 1'b0;
    byte_op_c       = 1'b0;
    illegal_c       = 1'b0;
    bus_err_c       = 1'b0;
    case (state_q)
      S_IF: begin
        instr_load_c = 1'b1;
        state_d      = S_DEC;
      end
      S_DEC: begin
        if (!dec_legal) begin
          illegal_c = 1'b1;
          pc_load_c = 1'b1;
          state_d   = S_IF;
        end else if (dec_branch) begin
          state_d = S_BR;
        end else begin
          state_d = S_EX;
        end
      end
      S_EX: begin
        alu_bin_sel_c = (op_q != OP_ALU);
        alu_a_zero_c  = (op_q == OP_LI) || (op_q == OP_LUI);
        case (op_q)
          OP_ALU:   alu_op_c = func;
          OP_NANDI: alu_op_c = 4'b0101;
          OP_ORI:   alu_op_c = 4'b0011;
          default:  alu_op_c = 4'b0000;
        endcase
        state_d = (is_load || is_store) ? S_MEM : S_WB;
      end
      S_MEM: begin
        dmem_req_c = 1'b1;
        dmem_we_c  = is_store;
        byte_op_c  = (op_q == OP_LB) || (op_q == OP_SB);
        if (dmem_ack) begin
          if (is_load) begin
            state_d = S_WB;
          end else begin
            pc_load_c = 1'b1;
            state_d   = S_IF;
          end
        end else if (cnt_q == CNT_LAST) begin
          bus_err_c = 1'b1;
          pc_load_c = 1'b1;
          state_d   = S_IF;
        end else begin
          cnt_d   = cnt_q + 4'd1;
          state_d = S_MEM;
        end
      end
      S_WB: begin
        rf_we_c         = 1'b1;
        rf_wrdata_sel_c = is_load;
        pc_load_c       = 1'b1;
        state_d         = S_IF;
      end
      S_BR: begin
        alu_op_c  = 4'b0001;
        pc_load_c = 1'b1;
        pc_sel_c  = (op_q == OP_B) ||
                    ((op_q == OP_BEQ) && alu_zero) ||
                    ((op_q == OP_BNE) && !alu_zero);
        state_d   = S_IF;
      end
      default: state_d = S_IF;
    endcase
  end

  // Outputs are forced low while reset is held, not just after the reset edge.
  assign instr_load    = instr_load_c    & ~reset;
  assign pc_load       = pc_load_c       & ~reset;
  assign pc_sel        = pc_sel_c        & ~reset;
  assign rf_we         = rf_we_c         & ~reset;
  assign rf_wrdata_sel = rf_wrdata_sel_c & ~reset;
  assign alu_a_zero    = alu_a_zero_c    & ~reset;
  assign alu_bin_sel   = alu_bin_sel_c   & ~reset;
  assign alu_op        = alu_op_c        & {4{~reset}};
  assign dmem_req      = dmem_req_c      & ~reset;
  assign dmem_we       = dmem_we_c       & ~reset;
  assign byte_op       = byte_op_c       & ~reset;
  assign illegal       = illegal_c       & ~reset;
  assign bus_err       = bus_err_c       & ~reset;
  assign state         = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class state by state
// and checks the control outputs against hand-derived values.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic [3:0] func;
  logic       alu_zero;
  logic       dmem_ack;
  logic       instr_load, pc_load, pc_sel, rf_we, rf_wrdata_sel;
  logic       alu_a_zero, alu_bin_sel, dmem_req, dmem_we, byte_op;
  logic       illegal, bus_err;
  logic [3:0] alu_op;
  logic [2:0] state;

  int errors = 0;
  int checks = 0;

  localparam logic [2:0] IF = 3'd0, DEC = 3'd1, EX = 3'd2, MEM = 3'd3, WB = 3'd4, BR = 3'd5;

  multicycle_control #(.MEM_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .func(func), .alu_zero(alu_zero),
    .dmem_ack(dmem_ack), .instr_load(instr_load), .pc_load(pc_load), .pc_sel(pc_sel),
    .rf_we(rf_we), .rf_wrdata_sel(rf_wrdata_sel), .alu_a_zero(alu_a_zero),
    .alu_bin_sel(alu_bin_sel), .alu_op(alu_op), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .byte_op(byte_op), .illegal(illegal), .bus_err(bus_err), .state(state)
  );

  always #5 clk = ~clk;

  logic [15:0] outs;
  assign outs = {instr_load, pc_load, pc_sel, rf_we, rf_wrdata_sel, alu_a_zero, alu_bin_sel,
                 alu_op, dmem_req, dmem_we, byte_op, illegal, bus_err};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic adv();
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; opcode = '0; func = '0; alu_zero = 1'b0; dmem_ack = 1'b0;
    adv(); adv();
    chk("rst_state", 32'(state), 32'(IF));
    chk("rst_outs", 32'(outs), 32'h0);
    reset = 1'b0; #1;
    chk("if_instr_load", 32'(instr_load), 1);
    chk("if_state", 32'(state), 32'(IF));

    // addi
    opcode = 6'b110000; adv();
    chk("addi_dec", 32'(state), 32'(DEC));
    chk("addi_dec_outs", 32'(outs), 32'h0);
    adv();
    chk("addi_ex", 32'(state), 32'(EX));
    chk("addi_ex_bin", 32'(alu_bin_sel), 1);
    chk("addi_ex_op", 32'(alu_op), 0);
    chk("addi_ex_azero", 32'(alu_a_zero), 0);
    adv();
    chk("addi_wb", 32'(state), 32'(WB));
    chk("addi_wb_rfwe", 32'(rf_we), 1);
    chk("addi_wb_pcld", 32'(pc_load), 1);
    chk("addi_wb_pcsel", 32'(pc_sel), 0);
    adv();
    chk("addi_back_if", 32'(state), 32'(IF));

    // R-type ALU with func pass-through
    opcode = 6'b100000; func = 4'b0101; adv(); adv();
    chk("alu_ex", 32'(state), 32'(EX));
    chk("alu_ex_op", 32'(alu_op), 4'b0101);
    chk("alu_ex_bin", 32'(alu_bin_sel), 0);
    func = 4'b0000; adv();
    chk("alu_wb", 32'(state), 32'(WB));
    chk("alu_wb_sel", 32'(rf_wrdata_sel), 0);
    chk("alu_wb_rfwe", 32'(rf_we), 1);
    adv();
    chk("alu_if", 32'(state), 32'(IF));

    // li: A operand forced to zero
    opcode = 6'b111000; adv(); adv();
    chk("li_azero", 32'(alu_a_zero), 1);
    chk("li_op", 32'(alu_op), 0);
    adv(); adv();
    // nandi / ori opcode mapping
    opcode = 6'b110010; adv(); adv();
    chk("nandi_op", 32'(alu_op), 4'b0101);
    adv(); adv();
    opcode = 6'b110011; adv(); adv();
    chk("ori_op", 32'(alu_op), 4'b0011);
    adv(); adv();

    // beq taken
    opcode = 6'b010000; alu_zero = 1'b1; adv(); adv();
    chk("beq1_state", 32'(state), 32'(BR));
    chk("beq1_pcsel", 32'(pc_sel), 1);
    chk("beq1_pcld", 32'(pc_load), 1);
    chk("beq1_op", 32'(alu_op), 4'b0001);
    chk("beq1_bin", 32'(alu_bin_sel), 0);
    adv();
    chk("beq1_if", 32'(state), 32'(IF));
    // beq not taken
    alu_zero = 1'b0; adv(); adv();
    chk("beq0_pcsel", 32'(pc_sel), 0);
    chk("beq0_pcld", 32'(pc_load), 1);
    adv();
    // b unconditional
    opcode = 6'b111111; adv(); adv();
    chk("b_pcsel", 32'(pc_sel), 1);
    adv();
    // bne with alu_zero=0 taken, alu_zero=1 not taken
    opcode = 6'b010001; adv(); adv();
    chk("bne0_pcsel", 32'(pc_sel), 1);
    alu_zero = 1'b1; #1;
    chk("bne1_pcsel", 32'(pc_sel), 0);
    alu_zero = 1'b0; adv();

    // lw: ack on third MEM cycle
    opcode = 6'b001111; adv(); adv(); adv();
    for (int i = 1; i <= 3; i++) begin
      if (i == 3) begin dmem_ack = 1'b1; #1; end
      chk($sformatf("lw_mem%0d_state", i), 32'(state), 32'(MEM));
      chk($sformatf("lw_mem%0d_req", i), 32'(dmem_req), 1);
      chk($sformatf("lw_mem%0d_we", i), 32'(dmem_we), 0);
      chk($sformatf("lw_mem%0d_pcld", i), 32'(pc_load), 0);
      adv();
    end
    dmem_ack = 1'b0; #1;
    chk("lw_wb", 32'(state), 32'(WB));
    chk("lw_wb_sel", 32'(rf_wrdata_sel), 1);
    chk("lw_wb_req", 32'(dmem_req), 0);
    adv();

    // sw without ack: bus error on 15th MEM cycle
    opcode = 6'b011111; adv(); adv(); adv();
    for (int i = 1; i <= 15; i++) begin
      chk($sformatf("swto_mem%0d_state", i), 32'(state), 32'(MEM));
      chk($sformatf("swto_mem%0d_we", i), 32'(dmem_we), 1);
      chk($sformatf("swto_mem%0d_berr", i), 32'(bus_err), (i == 15) ? 1 : 0);
      chk($sformatf("swto_mem%0d_pcld", i), 32'(pc_load), (i == 15) ? 1 : 0);
      adv();
    end
    chk("swto_if", 32'(state), 32'(IF));
    chk("swto_berr_clr", 32'(bus_err), 0);

    // sw with ack on 15th cycle: ack wins
    adv(); adv(); adv();
    for (int i = 1; i <= 14; i++) adv();
    dmem_ack = 1'b1; #1;
    chk("swack_state", 32'(state), 32'(MEM));
    chk("swack_berr", 32'(bus_err), 0);
    chk("swack_pcld", 32'(pc_load), 1);
    adv();
    dmem_ack = 1'b0; #1;
    chk("swack_if", 32'(state), 32'(IF));

    // sb with ack held high throughout: ack outside MEM ignored
    opcode = 6'b000111; dmem_ack = 1'b1; #1;
    chk("sb_if", 32'(state), 32'(IF));
    adv();
    chk("sb_dec", 32'(state), 32'(DEC));
    adv();
    chk("sb_ex", 32'(state), 32'(EX));
    adv();
    chk("sb_mem", 32'(state), 32'(MEM));
    chk("sb_byte", 32'(byte_op), 1);
    chk("sb_we", 32'(dmem_we), 1);
    adv();
    dmem_ack = 1'b0; #1;
    chk("sb_if2", 32'(state), 32'(IF));

    // illegal opcode
    opcode = 6'b101010; adv();
    chk("ill_dec", 32'(state), 32'(DEC));
    chk("ill_pulse", 32'(illegal), 1);
    chk("ill_pcld", 32'(pc_load), 1);
    adv();
    chk("ill_if", 32'(state), 32'(IF));
    chk("ill_clr", 32'(illegal), 0);

    // reset mid-MEM
    opcode = 6'b001111; adv(); adv(); adv(); adv();
    chk("rstm_mem", 32'(state), 32'(MEM));
    reset = 1'b1; adv();
    chk("rstm_state", 32'(state), 32'(IF));
    chk("rstm_outs", 32'(outs), 32'h0);
    reset = 1'b0; #1;
    chk("rstm_fetch", 32'(instr_load), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

endmodule
